// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register and its mode controller.
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      M_HOLD = MODE_HOLD,
      M_SHR  = MODE_SHR,
      M_SHL  = MODE_SHL,
      M_LOAD = MODE_LOAD
   } usr_mode_t;

endpackage

// File: rtl/usr_word_counter.sv
// Counts shifts modulo WIDTH and pulses done for one cycle as each word completes.
module usr_word_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   // Clear dominates; a non-shifting cycle always drops the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (shift_en) begin
         if (cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            done <= 1'b0;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load, sync clear, gated outputs.
// Optional registered parity output enabled by defining USR_PARITY_EN.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0,
   input  logic             s1,
   input  logic             mr,
   input  logic             g1,
   input  logic             g2,
   input  logic             dsr_i,
   input  logic             dsl_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             q_oe_o,
   output logic             q0_o,
   output logic             qmsb_o,
   output logic [CNT_W-1:0] shift_cnt_o,
`ifdef USR_PARITY_EN
   output logic             parity_o,
`endif
   output logic             word_done_o
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next;
   logic             shift_en;
   logic             cnt_clr;
   usr_mode_t        mode;

   assign mode = usr_mode_t'({s0, s1});

   // Next-state data path; master clear overrides every mode.
   always_comb begin
      q_next   = q_r;
      shift_en = 1'b0;
      cnt_clr  = 1'b0;
      if (!mr) begin
         q_next  = '0;
         cnt_clr = 1'b1;
      end else begin
         case (mode)
            M_SHR: begin
               q_next   = {dsr_i, q_r[WIDTH-1:1]};
               shift_en = 1'b1;
            end
            M_SHL: begin
               q_next   = {q_r[WIDTH-2:0], dsl_i};
               shift_en = 1'b1;
            end
            M_LOAD: begin
               q_next  = d_i;
               cnt_clr = 1'b1;
            end
            default: q_next = q_r;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_r <= '0;
      else        q_r <= q_next;
   end

`ifdef USR_PARITY_EN
   // Parity tracks q_r on the same edge so it always equals ^q_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_o <= 1'b0;
      else        parity_o <= ^q_next;
   end
`endif

   usr_word_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_word_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .clr      (cnt_clr),
      .cnt      (shift_cnt_o),
      .done     (word_done_o)
   );

   // Enables gate only the parallel bus; serial taps stay live for cascading.
   assign q_oe_o = ~(g1 | g2);
   assign q_o    = q_oe_o ? q_r : '0;
   assign q0_o   = q_r[0];
   assign qmsb_o = q_r[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8) with a behavioural reference model.
module tb_universal_shift_reg;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n, s0, s1, mr, g1, g2, dsr_i, dsl_i;
   logic [W-1:0]  d_i, q_o;
   logic          q_oe_o, q0_o, qmsb_o, word_done_o;
   logic [CW-1:0] shift_cnt_o;
`ifdef USR_PARITY_EN
   logic          parity_o;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [W-1:0] m_q;
   int           m_cnt;
   logic         m_done;

   universal_shift_reg #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s0          (s0),
      .s1          (s1),
      .mr          (mr),
      .g1          (g1),
      .g2          (g2),
      .dsr_i       (dsr_i),
      .dsl_i       (dsl_i),
      .d_i         (d_i),
      .q_o         (q_o),
      .q_oe_o      (q_oe_o),
      .q0_o        (q0_o),
      .qmsb_o      (qmsb_o),
      .shift_cnt_o (shift_cnt_o),
`ifdef USR_PARITY_EN
      .parity_o    (parity_o),
`endif
      .word_done_o (word_done_o)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic mr_v, input logic [1:0] mode, input logic dsr, input logic dsl,
                        input logic [W-1:0] d);
      mr = mr_v; s0 = mode[1]; s1 = mode[0]; dsr_i = dsr; dsl_i = dsl; d_i = d;
   endtask

   task automatic model_clear();
      m_q = '0; m_cnt = 0; m_done = 1'b0;
   endtask

   // One rising edge, then advance the model with the inputs the DUT sampled.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!mr) model_clear();
      else begin
         case ({s0, s1})
            2'b00: m_done = 1'b0;
            2'b11: begin m_q = d_i; m_cnt = 0; m_done = 1'b0; end
            default: begin
               if ({s0, s1} == 2'b01) m_q = W'((int'(m_q) / 2) + (int'(dsr_i) << (W - 1)));
               else                   m_q = W'((int'(m_q) * 2) + int'(dsl_i));
               m_cnt = m_cnt + 1;
               m_done = (m_cnt == W);
               if (m_cnt == W) m_cnt = 0;
            end
         endcase
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; g1 = 1'b0; g2 = 1'b0;
      drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
      model_clear();
      #12;
      checks++;
      if (q_o !== 8'h00 || q0_o !== 1'b0 || qmsb_o !== 1'b0 || shift_cnt_o !== '0 || word_done_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: q=%h q0=%b qmsb=%b cnt=%0d done=%b, required all zero",
                  q_o, q0_o, qmsb_o, shift_cnt_o, word_done_o);
      end
      checks++;
      if (q_oe_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_oe: q_oe=%b required 1", q_oe_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
      tick();
      checks++;
      if (q_o !== 8'hA5 || q_oe_o !== 1'b1 || q0_o !== 1'b1 || qmsb_o !== 1'b1 || shift_cnt_o !== '0) begin
         failures++;
         $display("FAIL load_a5: q=%h oe=%b q0=%b qmsb=%b cnt=%0d, required a5 1 1 1 0",
                  q_o, q_oe_o, q0_o, qmsb_o, shift_cnt_o);
      end
   endtask

   task automatic test_right_shift_word();
      logic [W-1:0] pat;
      pat = 8'hA5;
      drive(1'b1, 2'b01, 1'b0, 1'b0, '0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (q0_o !== pat[i]) begin
            failures++;
            $display("FAIL shr_q0_%0d: q0=%b required %b", i, q0_o, pat[i]);
         end
         tick();
         checks++;
         if (word_done_o !== (i == 7)) begin
            failures++;
            $display("FAIL shr_done_%0d: done=%b required %b", i, word_done_o, (i == 7));
         end
      end
      checks++;
      if (q_o !== 8'h00 || shift_cnt_o !== '0) begin
         failures++;
         $display("FAIL shr_final: q=%h cnt=%0d required 00 0", q_o, shift_cnt_o);
      end
      drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
      tick();
      checks++;
      if (word_done_o !== 1'b0) begin
         failures++;
         $display("FAIL shr_done_one_cycle: done=%b required 0", word_done_o);
      end
   endtask

   task automatic test_mixed_shift();
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h01);
      tick();
      drive(1'b1, 2'b10, 1'b0, 1'b1, '0);
      repeat (3) tick();
      checks++;
      if (q_o !== 8'h0F || shift_cnt_o !== CW'(3)) begin
         failures++;
         $display("FAIL shl_three: q=%h cnt=%0d required 0f 3", q_o, shift_cnt_o);
      end
      drive(1'b1, 2'b01, 1'b1, 1'b0, '0);
      tick();
      checks++;
      if (q_o !== 8'h87 || shift_cnt_o !== CW'(4)) begin
         failures++;
         $display("FAIL mixed_shr: q=%h cnt=%0d required 87 4", q_o, shift_cnt_o);
      end
   endtask

   task automatic test_gating();
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
      tick();
      drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
      g1 = 1'b1;
      tick();
      checks++;
      if (q_o !== 8'h00 || q_oe_o !== 1'b0 || qmsb_o !== 1'b0 || q0_o !== 1'b0) begin
         failures++;
         $display("FAIL gate_off: q=%h oe=%b qmsb=%b q0=%b required 00 0 0 0", q_o, q_oe_o, qmsb_o, q0_o);
      end
      g1 = 1'b0; g2 = 1'b1;
      #1;
      checks++;
      if (q_o !== 8'h00 || q_oe_o !== 1'b0) begin
         failures++;
         $display("FAIL gate_g2: q=%h oe=%b required 00 0", q_o, q_oe_o);
      end
      g2 = 1'b0;
      #1;
      checks++;
      if (q_o !== 8'h3C || q_oe_o !== 1'b1 || shift_cnt_o !== '0) begin
         failures++;
         $display("FAIL gate_restore: q=%h oe=%b cnt=%0d required 3c 1 0", q_o, q_oe_o, shift_cnt_o);
      end
   endtask

   task automatic test_clear_priority();
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
      tick();
      drive(1'b1, 2'b01, 1'b0, 1'b0, '0);
      tick();
      drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h55);
      tick();
      checks++;
      if (q_o !== 8'h00 || shift_cnt_o !== '0 || word_done_o !== 1'b0) begin
         failures++;
         $display("FAIL clear_wins: q=%h cnt=%0d done=%b required 00 0 0", q_o, shift_cnt_o, word_done_o);
      end
      drive(1'b1, 2'b00, 1'b1, 1'b1, 8'hAA);
      repeat (5) tick();
      checks++;
      if (q_o !== 8'h00 || shift_cnt_o !== '0) begin
         failures++;
         $display("FAIL clear_hold: q=%h cnt=%0d required 00 0", q_o, shift_cnt_o);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hC3);
      tick();
      drive(1'b1, 2'b10, 1'b0, 1'b1, '0);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (q_o !== 8'h00 || shift_cnt_o !== '0 || q0_o !== 1'b0 || qmsb_o !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: q=%h cnt=%0d q0=%b qmsb=%b required 00 0 0 0",
                  q_o, shift_cnt_o, q0_o, qmsb_o);
      end
      model_clear();
      drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef USR_PARITY_EN
      checks++;
      if (parity_o !== 1'b0) begin
         failures++;
         $display("FAIL parity_reset: parity=%b required 0", parity_o);
      end
      drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h07);
      tick();
      checks++;
      if (parity_o !== 1'b1) begin
         failures++;
         $display("FAIL parity_07: parity=%b required 1", parity_o);
      end
`endif
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q;
      int           r;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         g1 = ($urandom_range(0, 3) == 0);
         g2 = ($urandom_range(0, 3) == 0);
         drive(r >= 4, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom));
         if (r >= 10 && r < 80 && {s0, s1} == 2'b11) drive(1'b1, 2'($urandom_range(1, 2)), dsr_i, dsl_i, d_i);
         tick();
         exp_q = (g1 | g2) ? '0 : m_q;
         checks++;
         if (q_o !== exp_q || q_oe_o !== ~(g1 | g2) || q0_o !== m_q[0] || qmsb_o !== m_q[W-1]
             || shift_cnt_o !== CW'(m_cnt) || word_done_o !== m_done) begin
            failures++;
            $display("FAIL random_%0d: q=%h oe=%b q0=%b qmsb=%b cnt=%0d done=%b required %h %b %b %b %0d %b",
                     i, q_o, q_oe_o, q0_o, qmsb_o, shift_cnt_o, word_done_o,
                     exp_q, ~(g1 | g2), m_q[0], m_q[W-1], m_cnt, m_done);
         end
`ifdef USR_PARITY_EN
         checks++;
         if (parity_o !== ^m_q) begin
            failures++;
            $display("FAIL random_parity_%0d: parity=%b required %b", i, parity_o, ^m_q);
         end
`endif
      end
      g1 = 1'b0; g2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_right_shift_word();
      test_mixed_shift();
      test_gating();
      test_clear_priority();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
